// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: next-PC arbitration, stall hold,
// redirect flush and instruction-memory timeout detection.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        imem_ack_i,
  output logic [31:0] pc_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  output logic        if_valid_o,
  output logic        if_flush_o,
  output logic [1:0]  state_o,
  output logic        fetch_err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STALL = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  localparam logic [7:0] LP_WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [7:0]  r_wait_cnt;
  logic [7:0]  w_wait_nxt;
  logic        r_err;
  logic        w_err_nxt;

  logic        w_run;
  logic        w_stall_st;
  logic        w_redirect;
  logic        w_accept;
  logic [31:0] w_raw_tgt;
  logic [31:0] w_target;

  assign w_run      = (r_state == S_RUN);
  assign w_stall_st = (r_state == S_STALL);
  assign w_redirect = (branch_i | jump_i) & (w_run | w_stall_st);
  assign w_accept   = w_run & ~stall_i & imem_ack_i;

  // Branch wins over jump; targets are word aligned.
  assign w_raw_tgt = branch_i ? branch_target_i : jump_target_i;
  assign w_target  = {w_raw_tgt[31:2], 2'b00};

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_wait_nxt  = r_wait_cnt;
    w_err_nxt   = r_err;
    if (!start_i) begin
      w_state_nxt = S_IDLE;
      w_pc_nxt    = RESET_PC;
      w_wait_nxt  = 8'd0;
      w_err_nxt   = 1'b0;
    end else if (w_redirect) begin
      w_state_nxt = S_RUN;
      w_pc_nxt    = w_target;
      w_wait_nxt  = 8'd0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = RESET_PC;
          w_wait_nxt  = 8'd0;
        end
        S_RUN: begin
          if (stall_i) begin
            w_state_nxt = S_STALL;
            w_wait_nxt  = 8'd0;
          end else if (imem_ack_i) begin
            w_pc_nxt   = r_pc + 32'd4;
            w_wait_nxt = 8'd0;
          end else if (r_wait_cnt == LP_WAIT_LAST) begin
            w_state_nxt = S_ERROR;
            w_err_nxt   = 1'b1;
          end else begin
            w_wait_nxt = r_wait_cnt + 8'd1;
          end
        end
        S_STALL: begin
          w_wait_nxt = 8'd0;
          if (!stall_i) begin
            w_state_nxt = S_RUN;
          end
        end
        S_ERROR: begin
          w_state_nxt = S_ERROR;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_wait_cnt <= 8'd0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign pc_o        = r_pc;
  assign imem_addr_o = r_pc;
  assign imem_req_o  = w_run & ~stall_i;
  assign if_valid_o  = w_accept & ~w_redirect;
  assign if_flush_o  = w_redirect;
  assign state_o     = r_state;
  assign fetch_err_o = r_err;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: directed plan steps followed by
// random traffic, all checked against a rule-level model.
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          MW     = 15;

  logic        clk = 1'b0;
  logic        rst_i, start_i, stall_i;
  logic        branch_i, jump_i, imem_ack_i;
  logic [31:0] branch_target_i, jump_target_i;
  logic [31:0] pc_o, imem_addr_o;
  logic        imem_req_o, if_valid_o, if_flush_o, fetch_err_o;
  logic [1:0]  state_o;

  int errs   = 0;
  int checks = 0;

  // Model state: mode 0 idle, 1 run, 2 stall, 3 error.
  logic [1:0]  m_st;
  logic [31:0] m_pc;
  int          m_cnt;
  logic        m_err;

  always #5 clk = ~clk;

  fetch_pc_ctrl #(.RESET_PC(RST_PC), .MAX_WAIT(MW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .stall_i(stall_i), .branch_i(branch_i),
    .branch_target_i(branch_target_i), .jump_i(jump_i),
    .jump_target_i(jump_target_i), .imem_ack_i(imem_ack_i),
    .pc_o(pc_o), .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o), .if_valid_o(if_valid_o),
    .if_flush_o(if_flush_o), .state_o(state_o),
    .fetch_err_o(fetch_err_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check mid-cycle, then advance the model at the edge.
  task automatic step(input logic rst, input logic st,
                      input logic stl, input logic br,
                      input logic [31:0] bt, input logic jp,
                      input logic [31:0] jt, input logic ack);
    logic redir, acc, active;
    logic [31:0] tgt;
    rst_i = rst; start_i = st; stall_i = stl;
    branch_i = br; branch_target_i = bt;
    jump_i = jp; jump_target_i = jt; imem_ack_i = ack;
    #4;
    active = (m_st == 2'd1) || (m_st == 2'd2);
    redir  = (br || jp) && active;
    acc    = (m_st == 2'd1) && !stl && ack;
    tgt    = br ? bt : jt;
    tgt[1:0] = 2'b00;
    chk("pc", pc_o, m_pc);
    chk("addr", imem_addr_o, m_pc);
    chk("state", {30'd0, state_o}, {30'd0, m_st});
    chk("err", {31'd0, fetch_err_o}, {31'd0, m_err});
    chk("req", {31'd0, imem_req_o},
        {31'd0, (m_st == 2'd1) && !stl});
    chk("valid", {31'd0, if_valid_o}, {31'd0, acc && !redir});
    chk("flush", {31'd0, if_flush_o}, {31'd0, redir});
    @(posedge clk);
    if (rst || !st) begin
      m_st = 2'd0; m_pc = RST_PC; m_cnt = 0; m_err = 1'b0;
    end else if (redir) begin
      m_st = 2'd1; m_pc = tgt; m_cnt = 0;
    end else if (m_st == 2'd3) begin
      m_st = 2'd3;
    end else if (m_st == 2'd0) begin
      m_st = 2'd1; m_cnt = 0;
    end else if (stl) begin
      m_st = 2'd2; m_cnt = 0;
    end else if (m_st == 2'd2) begin
      m_st = 2'd1;
    end else if (ack) begin
      m_pc = m_pc + 32'd4; m_cnt = 0;
    end else if (m_cnt == MW - 1) begin
      m_st = 2'd3; m_err = 1'b1;
    end else begin
      m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0;
    branch_i = 1'b0; jump_i = 1'b0; imem_ack_i = 1'b0;
    branch_target_i = '0; jump_target_i = '0;
    m_st = 2'd0; m_pc = RST_PC; m_cnt = 0; m_err = 1'b0;
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_pc", pc_o, 32'h0);
    // Start with continuous ack: IDLE, then 0,4,8,C
    step(0, 1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", pc_o, 32'(i * 4));
      step(0, 1, 0, 0, 0, 0, 0, 1);
    end
    // Stall at 0x10 for three cycles
    chk("stall_start_pc", pc_o, 32'h10);
    for (int i = 0; i < 3; i++)
      step(0, 1, 1, 0, 0, 0, 0, 1);
    chk("stall_hold_pc", pc_o, 32'h10);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    chk("post_stall_pc", pc_o, 32'h14);
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 0, 0, 0, 0, 1);
    // Branch and jump together at 0x20 with ack
    chk("prio_pc_before", pc_o, 32'h20);
    step(0, 1, 0, 1, 32'h103, 1, 32'h400, 1);
    chk("prio_pc_after", pc_o, 32'h100);
    // Redirect while stalled
    step(0, 1, 0, 0, 0, 1, 32'h40, 0);
    step(0, 1, 1, 0, 0, 0, 0, 0);
    chk("stall_state", {30'd0, state_o}, 32'd2);
    step(0, 1, 1, 0, 0, 1, 32'h80, 0);
    chk("stall_redir_pc", pc_o, 32'h80);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    // Timeout: 15 unacked request cycles
    for (int i = 0; i < MW; i++)
      step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("timeout_err", {31'd0, fetch_err_o}, 32'd1);
    step(0, 1, 1, 1, 32'h500, 0, 0, 1);
    chk("err_frozen_pc", pc_o, 32'h84);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("err_clear", {31'd0, fetch_err_o}, 32'd0);
    // Wrap from the last word address
    step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 1, 32'hFFFF_FFFF, 0);
    chk("wrap_pre", pc_o, 32'hFFFF_FFFC);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    chk("wrap_post", pc_o, 32'h0);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 29) != 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 9) == 0, $urandom,
           $urandom_range(0, 9) == 0, $urandom,
           $urandom_range(0, 9) < 6);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
